// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle for the shared 4-bit ALU: two valid/ready requesters,
// one tagged response channel and the per-requester serviced-op counters.
interface alu_share_arbiter_if #(
  parameter int CNT_W = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [3:0]       req0_a;
  logic [3:0]       req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [3:0]       req1_a;
  logic [3:0]       req1_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [3:0]       resp_d;
  logic             resp_id;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_d, resp_id, cnt0, cnt1
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_d, resp_id, cnt0, cnt1
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one 4-bit ALU (AND/SHL/OR/SHR) between two requesters,
// with a single registered response slot that can drain and refill in one cycle.
module alu_share_arbiter #(
  parameter int CNT_W      = 8,
  parameter int PRIO_RESET = 0
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  bus
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_last;
  logic [3:0]              r_resp_d;
  logic                    r_resp_id;
  logic [1:0][CNT_W-1:0]   r_cnt;

  logic                    w_can_issue;
  logic [1:0]              w_vld, w_gnt;
  logic [1:0][1:0]         w_op;
  logic [1:0][3:0]         w_a, w_b;
  logic                    w_win;
  logic [3:0]              w_res;

  function automatic logic [3:0] alu4(input logic [1:0] op, input logic [3:0] a,
                                      input logic [3:0] b);
    logic [3:0] res;
    res = '0;
    unique case (op)
      2'b00: res = a & b;
      2'b01: res = (b[3:2] != 2'b00) ? 4'h0 : (a << b[1:0]);
      2'b10: res = a | b;
      2'b11: res = (b[3:2] != 2'b00) ? 4'h0 : (a >> b[1:0]);
      default: res = '0;
    endcase
    return res;
  endfunction

  assign w_vld = {bus.req1_valid, bus.req0_valid};
  assign w_op  = {bus.req1_op, bus.req0_op};
  assign w_a   = {bus.req1_a, bus.req0_a};
  assign w_b   = {bus.req1_b, bus.req0_b};

  // Reset masks issue so no ready can leak out during rst.
  assign w_can_issue = !rst && ((r_state == S_EMPTY) || bus.resp_ready);

  // r_last holds the previous winner; a tie goes to the other requester.
  assign w_gnt[0] = w_can_issue && w_vld[0] && (!w_vld[1] || r_last);
  assign w_gnt[1] = w_can_issue && w_vld[1] && (!w_vld[0] || !r_last);
  assign w_win    = w_gnt[1];
  assign w_res    = alu4(w_op[w_win], w_a[w_win], w_b[w_win]);

  assign bus.req0_ready = w_gnt[0];
  assign bus.req1_ready = w_gnt[1];
  assign bus.resp_valid = (r_state == S_FULL);
  assign bus.resp_d     = r_resp_d;
  assign bus.resp_id    = r_resp_id;
  assign bus.cnt0       = r_cnt[0];
  assign bus.cnt1       = r_cnt[1];

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_EMPTY: if (|w_gnt) w_state_nxt = S_FULL;
      S_FULL: begin
        if (|w_gnt)               w_state_nxt = S_FULL;
        else if (bus.resp_ready)  w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_EMPTY;
      r_last    <= (PRIO_RESET == 0);
      r_resp_d  <= '0;
      r_resp_id <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (|w_gnt) begin
        r_last    <= w_win;
        r_resp_d  <= w_res;
        r_resp_id <= w_win;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst)           r_cnt[g] <= '0;
      else if (w_gnt[g]) r_cnt[g] <= r_cnt[g] + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter against a cycle-level
// model of the arbitration rules and an arithmetic ALU reference.
module tb_alu_share_arbiter;
  localparam int CNT_W      = 8;
  localparam int PRIO_RESET = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.CNT_W(CNT_W)) bus ();
  alu_share_arbiter #(.CNT_W(CNT_W), .PRIO_RESET(PRIO_RESET)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Model state
  bit               m_full;
  logic [3:0]       m_d;
  bit               m_id;
  bit               m_last;
  logic [CNT_W-1:0] m_cnt0, m_cnt1;
  bit               e_g0, e_g1, o_r0, o_r1;

  function automatic logic [3:0] alu_ref(input int op, input int a, input int b);
    int r;
    case (op)
      0:       r = a & b;
      1:       r = (a * (1 << b)) % 16;
      2:       r = a | b;
      default: r = a / (1 << b);
    endcase
    return 4'(r);
  endfunction

  task automatic set_req(input int n, input bit v, input logic [1:0] op,
                         input logic [3:0] a, input logic [3:0] b);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  // Advance one cycle: sample readies before the edge, step the model, settle after.
  task automatic tick();
    bit can, rr;
    logic [3:0] d0, d1;
    #1;
    o_r0 = bus.req0_ready;
    o_r1 = bus.req1_ready;
    rr   = bus.resp_ready;
    can  = !rst && (!m_full || rr);
    e_g0 = 0; e_g1 = 0;
    if (can) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (m_last) e_g0 = 1; else e_g1 = 1;
      end else if (bus.req0_valid) e_g0 = 1;
      else if (bus.req1_valid)     e_g1 = 1;
    end
    d0 = alu_ref(int'(bus.req0_op), int'(bus.req0_a), int'(bus.req0_b));
    d1 = alu_ref(int'(bus.req1_op), int'(bus.req1_a), int'(bus.req1_b));
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_d = 0; m_id = 0; m_last = (PRIO_RESET == 0);
      m_cnt0 = 0; m_cnt1 = 0;
    end else if (e_g0 || e_g1) begin
      m_full = 1; m_id = e_g1; m_last = e_g1;
      m_d = e_g1 ? d1 : d0;
      if (e_g1) m_cnt1 = m_cnt1 + 1'b1; else m_cnt0 = m_cnt0 + 1'b1;
    end else if (m_full && rr) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    set_req(0, 1, 2'b10, 4'h3, 4'h5);
    set_req(1, 1, 2'b00, 4'hF, 4'hF);
    bus.resp_ready = 1;
    tick(); tick();
    n_chk++; if ({o_r1, o_r0} !== 2'b00) $display("FAIL reset_ready got=%b want=00", {o_r1, o_r0}); else n_pass++;
    set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
    rst = 0;
    n_chk++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", bus.resp_valid); else n_pass++;
    n_chk++; if (bus.resp_d !== 4'h0 || bus.resp_id !== 1'b0) $display("FAIL reset_resp got=%h/%b want=0/0", bus.resp_d, bus.resp_id); else n_pass++;
    n_chk++; if (bus.cnt0 !== '0 || bus.cnt1 !== '0) $display("FAIL reset_cnt got=%0d/%0d want=0/0", bus.cnt0, bus.cnt1); else n_pass++;
  endtask

  task automatic test_basic();
    bus.resp_ready = 1;
    set_req(0, 1, 2'b00, 4'b1100, 4'b1010);
    tick();
    set_req(0, 0, 0, 0, 0);
    n_chk++; if (o_r0 !== 1'b1) $display("FAIL basic_ready got=%b want=1", o_r0); else n_pass++;
    n_chk++; if ({bus.resp_valid, bus.resp_id, bus.resp_d} !== {1'b1, 1'b0, 4'b1000})
      $display("FAIL basic_resp got=%b/%b/%b want=1/0/1000", bus.resp_valid, bus.resp_id, bus.resp_d); else n_pass++;
    n_chk++; if (bus.cnt0 !== 8'd1) $display("FAIL basic_cnt0 got=%0d want=1", bus.cnt0); else n_pass++;
    tick();
    n_chk++; if (bus.resp_valid !== 1'b0 || bus.resp_d !== 4'b1000)
      $display("FAIL basic_drain got=%b/%b want=0/1000", bus.resp_valid, bus.resp_d); else n_pass++;
  endtask

  task automatic test_alternate();
    logic [3:0] exp_d;
    do_reset();
    bus.resp_ready = 1;
    set_req(0, 1, 2'b10, 4'b0001, 4'b0010);
    set_req(1, 1, 2'b01, 4'b0011, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_d = (i % 2 == 0) ? 4'b0011 : 4'b0110;
      n_chk++; if (bus.resp_id !== 1'(i % 2) || bus.resp_d !== exp_d || bus.resp_valid !== 1'b1)
        $display("FAIL alt_%0d got=%b/%b want=%0d/%b", i, bus.resp_id, bus.resp_d, i % 2, exp_d); else n_pass++;
    end
    n_chk++; if (bus.cnt0 !== 8'd2 || bus.cnt1 !== 8'd2) $display("FAIL alt_cnt got=%0d/%0d want=2/2", bus.cnt0, bus.cnt1); else n_pass++;
    set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_backpressure();
    logic [3:0] held_d;
    bit held_id;
    bus.resp_ready = 1;
    set_req(1, 1, 2'b10, 4'b1000, 4'b0001);
    tick();
    held_d = 4'b1001; held_id = 1;
    bus.resp_ready = 0;
    set_req(0, 1, 2'b00, 4'hF, 4'h6);
    set_req(1, 1, 2'b11, 4'hC, 4'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if ({o_r1, o_r0} !== 2'b00) $display("FAIL bp_ready_%0d got=%b want=00", i, {o_r1, o_r0}); else n_pass++;
      n_chk++; if ({bus.resp_valid, bus.resp_id, bus.resp_d} !== {1'b1, held_id, held_d})
        $display("FAIL bp_hold_%0d got=%b/%b/%b want=1/%b/%b", i, bus.resp_valid, bus.resp_id, bus.resp_d, held_id, held_d); else n_pass++;
    end
    bus.resp_ready = 1;
    tick();
    n_chk++; if ({o_r1, o_r0} !== 2'b01) $display("FAIL bp_reissue_ready got=%b want=01", {o_r1, o_r0}); else n_pass++;
    n_chk++; if ({bus.resp_valid, bus.resp_id, bus.resp_d} !== {1'b1, 1'b0, 4'b0110})
      $display("FAIL bp_reissue got=%b/%b/%b want=1/0/0110", bus.resp_valid, bus.resp_id, bus.resp_d); else n_pass++;
    set_req(0, 0, 0, 0, 0);
    tick();
    set_req(1, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_shift_bounds();
    logic [1:0] ops [3] = '{2'b01, 2'b11, 2'b11};
    logic [3:0] as  [3] = '{4'b1111, 4'b1000, 4'b1111};
    logic [3:0] bs  [3] = '{4'b0100, 4'b0011, 4'b1111};
    logic [3:0] exp [3] = '{4'b0000, 4'b0001, 4'b0000};
    bus.resp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      set_req(0, 1, ops[i], as[i], bs[i]);
      tick();
      n_chk++; if (bus.resp_d !== exp[i] || bus.resp_id !== 1'b0)
        $display("FAIL shift_%0d got=%b want=%b", i, bus.resp_d, exp[i]); else n_pass++;
    end
    set_req(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_mid();
    bus.resp_ready = 0;
    set_req(0, 1, 2'b10, 4'h1, 4'h2);
    set_req(1, 1, 2'b10, 4'h4, 4'h8);
    tick();
    rst = 1;
    tick();
    n_chk++; if ({o_r1, o_r0} !== 2'b00) $display("FAIL rstmid_ready got=%b want=00", {o_r1, o_r0}); else n_pass++;
    n_chk++; if (bus.resp_valid !== 1'b0 || bus.cnt0 !== '0 || bus.cnt1 !== '0)
      $display("FAIL rstmid_state got=%b/%0d/%0d want=0/0/0", bus.resp_valid, bus.cnt0, bus.cnt1); else n_pass++;
    rst = 0;
    bus.resp_ready = 1;
    tick();
    n_chk++; if (bus.resp_id !== 1'(PRIO_RESET) || bus.resp_d !== 4'h3)
      $display("FAIL rstmid_prio got=%b/%h want=%0d/3", bus.resp_id, bus.resp_d, PRIO_RESET); else n_pass++;
    set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.resp_ready = 1;
    for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
      set_req(1, 1, 2'($urandom), 4'($urandom), 4'($urandom));
      tick();
      n_chk++; if (o_r1 !== 1'b1 || bus.resp_d !== m_d || bus.resp_id !== 1'b1)
        $display("FAIL wrap_op_%0d got=%b/%b want=1/%b", i, o_r1, bus.resp_d, m_d); else n_pass++;
    end
    n_chk++; if (bus.cnt1 !== 8'd1 || bus.cnt0 !== 8'd0) $display("FAIL wrap_cnt got=%0d/%0d want=0/1", bus.cnt0, bus.cnt1); else n_pass++;
    set_req(1, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      if (!bus.req0_valid || o_r0)
        set_req(0, ($urandom % 4) != 0, 2'($urandom), 4'($urandom), 4'($urandom));
      if (!bus.req1_valid || o_r1)
        set_req(1, ($urandom % 4) != 0, 2'($urandom), 4'($urandom), 4'($urandom));
      bus.resp_ready = ($urandom % 3) != 0;
      tick();
      n_chk++; if ({o_r1, o_r0} !== {e_g1, e_g0}) $display("FAIL rnd_ready_%0d got=%b want=%b", i, {o_r1, o_r0}, {e_g1, e_g0}); else n_pass++;
      n_chk++; if ({bus.resp_valid, bus.resp_id, bus.resp_d} !== {m_full, m_id, m_d})
        $display("FAIL rnd_resp_%0d got=%b/%b/%b want=%b/%b/%b", i, bus.resp_valid, bus.resp_id, bus.resp_d, m_full, m_id, m_d); else n_pass++;
      n_chk++; if (bus.cnt0 !== m_cnt0 || bus.cnt1 !== m_cnt1)
        $display("FAIL rnd_cnt_%0d got=%0d/%0d want=%0d/%0d", i, bus.cnt0, bus.cnt1, m_cnt0, m_cnt1); else n_pass++;
    end
  endtask

  initial begin
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    bus.resp_ready = 0;
    test_reset();
    test_basic();
    test_alternate();
    test_backpressure();
    test_shift_bounds();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
